pipe_stall_ctrl: RTL and testbench

- Central pipeline controller for the six-stage MIPS core.
- Merges per-stage stall requests into the stall[5:0] vector consumed by every pipeline register, including the MEM/WB register.
- Converts MEM-stage exceptions into a one-cycle flush with a redirect PC, then masks spurious exceptions for a programmable window.
- Provides a stall watchdog and a saturating stall-cycle performance counter.

---
 rtl/pipe_stall_ctrl.sv | 130 +++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline controller: merges stage stall requests, turns MEM-stage exceptions
// into a one-cycle flush with redirect, and tracks stall watchdog/perf counts.
module pipe_stall_ctrl #(
  parameter logic [31:0] EXC_VECTOR     = 32'h00000020,
  parameter logic [31:0] ERET_CODE      = 32'h0000000e,
  parameter int unsigned MASK_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wd_clear,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        wd_timeout,
  output logic [31:0] stall_cycles
);

  typedef enum logic {
    RUN  = 1'b0,
    MASK = 1'b1
  } state_t;

  localparam logic [3:0]  MASK_LOAD = 4'(MASK_CYCLES - 1);
  localparam logic [15:0] WD_LIMIT  = 16'(TIMEOUT_CYCLES);

  state_t      state_reg;
  logic [3:0]  mask_cnt_reg;
  logic [15:0] wd_cnt_reg;
  logic        wd_timeout_reg;
  logic [31:0] stall_cycles_reg;

  logic        exc_take;
  logic        stall_active;
  logic [15:0] wd_inc;
  logic        wd_hit;

  // Outputs are held quiet while reset is asserted, whatever the requests say.
  assign exc_take = rst && (excepttype_i != '0) && (state_reg != MASK);
  assign flush    = exc_take;

  always_comb begin
    new_pc = '0;
    if (exc_take) begin
      new_pc = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
    end
  end

  always_comb begin
    stall = 6'b000000;
    if (!rst || exc_take) begin
      stall = 6'b000000;
    end else if (stallreq_mem) begin
      stall = 6'b011111;
    end else if (stallreq_ex) begin
      stall = 6'b001111;
    end else if (stallreq_id || stallreq_if) begin
      stall = 6'b000111;
    end
  end

  assign stall_active = (stall != 6'b000000);
  assign wd_inc       = wd_cnt_reg + 16'd1;
  // Counter never exceeds the limit, so only the exact crossing can fire.
  assign wd_hit       = stall_active && (wd_cnt_reg != WD_LIMIT) && (wd_inc == WD_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= RUN;
      mask_cnt_reg <= '0;
    end else begin
      case (state_reg)
        RUN: begin
          if (exc_take) begin
            state_reg    <= MASK;
            mask_cnt_reg <= MASK_LOAD;
          end
        end
        MASK: begin
          if (mask_cnt_reg == 4'd0) begin
            state_reg <= RUN;
          end else begin
            mask_cnt_reg <= mask_cnt_reg - 4'd1;
          end
        end
        default: begin
          state_reg    <= RUN;
          mask_cnt_reg <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_reg     <= '0;
      wd_timeout_reg <= 1'b0;
    end else begin
      if (!stall_active || flush) begin
        wd_cnt_reg <= '0;
      end else if (wd_cnt_reg != WD_LIMIT) begin
        wd_cnt_reg <= wd_inc;
      end
      // A timeout landing in the same cycle as a clear must stay visible.
      if (wd_hit) begin
        wd_timeout_reg <= 1'b1;
      end else if (wd_clear) begin
        wd_timeout_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_reg <= '0;
    end else if (stall_active && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end
  end

  assign wd_timeout   = wd_timeout_reg;
  assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: vector table, directed corner
// sequences and a random phase compared against a cycle-level reference model.
module tb_pipe_stall_ctrl;

  localparam logic [31:0] EXC_VECTOR     = 32'h00000020;
  localparam logic [31:0] ERET_CODE      = 32'h0000000e;
  localparam int          MASK_CYCLES    = 2;
  localparam int          TIMEOUT_CYCLES = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic        wd_clear;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        wd_timeout;
  logic [31:0] stall_cycles;

  pipe_stall_ctrl #(
    .EXC_VECTOR    (EXC_VECTOR),
    .ERET_CODE     (ERET_CODE),
    .MASK_CYCLES   (MASK_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_if (stallreq_if),
    .stallreq_id (stallreq_id),
    .stallreq_ex (stallreq_ex),
    .stallreq_mem(stallreq_mem),
    .excepttype_i(excepttype_i),
    .cp0_epc_i   (cp0_epc_i),
    .wd_clear    (wd_clear),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .wd_timeout  (wd_timeout),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: masked cycles still to come, consecutive stall
  // count, sticky timeout flag and the total stalled-cycle count.
  int              m_mask_left;
  int              m_wd;
  bit              m_to;
  longint unsigned m_sc;
  logic [5:0]      e_stall;
  logic            e_flush;
  logic [31:0]     e_pc;

  typedef struct packed {
    logic       mem;
    logic       ex;
    logic       id;
    logic       ifr;
    logic [5:0] exp_stall;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_mask_left = 0;
    m_wd        = 0;
    m_to        = 1'b0;
    m_sc        = 0;
  endfunction

  function automatic void model_comb();
    e_flush = rst && (excepttype_i != 0) && (m_mask_left == 0);
    e_pc    = !e_flush ? 32'h0 : (excepttype_i == ERET_CODE ? cp0_epc_i : EXC_VECTOR);
    if (!rst || e_flush)                e_stall = 6'b000000;
    else if (stallreq_mem)              e_stall = 6'b011111;
    else if (stallreq_ex)               e_stall = 6'b001111;
    else if (stallreq_id || stallreq_if) e_stall = 6'b000111;
    else                                e_stall = 6'b000000;
  endfunction

  function automatic void model_edge();
    bit fire;
    fire = 1'b0;
    if (e_flush) m_mask_left = MASK_CYCLES;
    else if (m_mask_left > 0) m_mask_left--;
    if (e_stall != 0) begin
      if (m_sc < 64'hFFFF_FFFF) m_sc++;
      if (m_wd < TIMEOUT_CYCLES) begin
        m_wd++;
        fire = (m_wd == TIMEOUT_CYCLES);
      end
    end else begin
      m_wd = 0;
    end
    if (fire) m_to = 1'b1;
    else if (wd_clear) m_to = 1'b0;
  endfunction

  // Called #1 after a rising edge with inputs already driven; returns #1
  // after the next rising edge.
  task automatic tick(input string tag, input bit has_exp, input logic [5:0] xs,
                      input logic xf, input logic [31:0] xp);
    @(negedge clk);
    model_comb();
    chk($sformatf("%s.stall", tag), {26'b0, stall}, {26'b0, e_stall});
    chk($sformatf("%s.flush", tag), {31'b0, flush}, {31'b0, e_flush});
    chk($sformatf("%s.new_pc", tag), new_pc, e_pc);
    if (has_exp) begin
      chk($sformatf("%s.stall_exp", tag), {26'b0, stall}, {26'b0, xs});
      chk($sformatf("%s.flush_exp", tag), {31'b0, flush}, {31'b0, xf});
      chk($sformatf("%s.new_pc_exp", tag), new_pc, xp);
    end
    @(posedge clk);
    model_edge();
    #1;
    chk($sformatf("%s.wd_timeout", tag), {31'b0, wd_timeout}, {31'b0, m_to});
    chk($sformatf("%s.stall_cycles", tag), stall_cycles, m_sc[31:0]);
  endtask

  task automatic clear_inputs();
    stallreq_if  = 1'b0;
    stallreq_id  = 1'b0;
    stallreq_ex  = 1'b0;
    stallreq_mem = 1'b0;
    excepttype_i = 32'h0;
    cp0_epc_i    = 32'h0;
    wd_clear     = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'b011111};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'b011111};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'b011111};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b000111};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b000111};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b001111};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'b001111};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b011111};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 6'b000111};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 6'b011111};

    clear_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    #11;
    chk("reset.stall", {26'b0, stall}, 32'h0);
    chk("reset.flush", {31'b0, flush}, 32'h0);
    chk("reset.new_pc", new_pc, 32'h0);
    chk("reset.wd_timeout", {31'b0, wd_timeout}, 32'h0);
    chk("reset.stall_cycles", stall_cycles, 32'h0);

    @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) tick("idle", 1'b1, 6'b000000, 1'b0, 32'h0);
    chk("idle.stall_cycles_zero", stall_cycles, 32'h0);

    for (int i = 0; i < 11; i++) begin
      stallreq_mem = tbl[i].mem;
      stallreq_ex  = tbl[i].ex;
      stallreq_id  = tbl[i].id;
      stallreq_if  = tbl[i].ifr;
      tick($sformatf("tbl%0d", i), 1'b1, tbl[i].exp_stall, 1'b0, 32'h0);
      if (i == 2) chk("tbl.stall_cycles_3", stall_cycles, 32'd3);
      if (i == 3) chk("tbl.stall_cycles_4", stall_cycles, 32'd4);
    end
    clear_inputs();

    // Exception, masked window, retake on the first RUN cycle, then ERET.
    stallreq_ex  = 1'b1;
    excepttype_i = 32'h8;
    tick("exc8", 1'b1, 6'b000000, 1'b1, 32'h20);
    excepttype_i = 32'hc;
    tick("mask1", 1'b1, 6'b001111, 1'b0, 32'h0);
    tick("mask2", 1'b1, 6'b001111, 1'b0, 32'h0);
    tick("retake", 1'b1, 6'b000000, 1'b1, 32'h20);
    clear_inputs();
    repeat (2) tick("mask_idle", 1'b1, 6'b000000, 1'b0, 32'h0);
    excepttype_i = ERET_CODE;
    cp0_epc_i    = 32'hbfc00100;
    tick("eret", 1'b1, 6'b000000, 1'b1, 32'hbfc00100);
    clear_inputs();
    repeat (2) tick("eret_idle", 1'b0, 6'b0, 1'b0, 32'h0);

    // Watchdog boundary: fires exactly on the TIMEOUT_CYCLES-th stalled edge.
    stallreq_mem = 1'b1;
    for (int k = 1; k <= TIMEOUT_CYCLES; k++) begin
      tick("wd", 1'b0, 6'b0, 1'b0, 32'h0);
      if (k == TIMEOUT_CYCLES - 1) chk("wd.before_limit", {31'b0, wd_timeout}, 32'h0);
      if (k == TIMEOUT_CYCLES)     chk("wd.at_limit", {31'b0, wd_timeout}, 32'h1);
    end
    stallreq_mem = 1'b0;
    repeat (3) tick("wd_sticky", 1'b0, 6'b0, 1'b0, 32'h0);
    chk("wd.sticky", {31'b0, wd_timeout}, 32'h1);
    wd_clear = 1'b1;
    tick("wd_clear", 1'b0, 6'b0, 1'b0, 32'h0);
    wd_clear = 1'b0;
    chk("wd.cleared", {31'b0, wd_timeout}, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      stallreq_mem = ($urandom_range(0, 3) == 0);
      stallreq_ex  = ($urandom_range(0, 3) == 0);
      stallreq_id  = ($urandom_range(0, 3) == 0);
      stallreq_if  = ($urandom_range(0, 3) == 0);
      cp0_epc_i    = $urandom;
      wd_clear     = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0:       excepttype_i = 32'h8;
          1:       excepttype_i = ERET_CODE;
          2:       excepttype_i = 32'h1;
          default: excepttype_i = $urandom | 32'h1;
        endcase
      end else begin
        excepttype_i = 32'h0;
      end
      tick("rnd", 1'b0, 6'b0, 1'b0, 32'h0);
    end
    clear_inputs();

    // Async reset in the middle of a masked window while EX is stalling.
    stallreq_mem = 1'b1;
    repeat (TIMEOUT_CYCLES) tick("wd2", 1'b0, 6'b0, 1'b0, 32'h0);
    chk("wd2.set", {31'b0, wd_timeout}, 32'h1);
    stallreq_mem = 1'b0;
    stallreq_ex  = 1'b1;
    excepttype_i = 32'h8;
    tick("rst_exc", 1'b1, 6'b000000, 1'b1, 32'h20);
    excepttype_i = 32'h0;
    tick("rst_mask", 1'b1, 6'b001111, 1'b0, 32'h0);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("midrst.wd_timeout", {31'b0, wd_timeout}, 32'h0);
    chk("midrst.stall_cycles", stall_cycles, 32'h0);
    chk("midrst.stall", {26'b0, stall}, 32'h0);
    chk("midrst.flush", {31'b0, flush}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst          = 1'b1;
    stallreq_ex  = 1'b0;
    excepttype_i = 32'h1;
    tick("post_rst", 1'b1, 6'b000000, 1'b1, 32'h20);
    clear_inputs();
    repeat (2) tick("final", 1'b0, 6'b0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
